// File: rtl/arm_multicycle_if.sv
// Unified instruction/data memory port of the multicycle core.
// master (core side): drives mem_req, mem_we, mem_addr, mem_wdata;
//                     samples mem_rdata and mem_ready.
// slave (memory side): the mirror image.
interface arm_multicycle_if #(
  parameter int unsigned WIDTH = 12
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/arm_multicycle.sv
// Multicycle 4-register ARM-like core sharing one memory port for fetch and load/store.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-low reset
//   bus        - memory port (master): req/we/addr/wdata out, rdata/ready in
//   instr_done - one-cycle pulse on the last cycle of each instruction
//   pc         - current PC register
module arm_multicycle #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  arm_multicycle_if.master bus,
  output logic             instr_done,
  output logic [WIDTH-1:0] pc
);

  localparam int unsigned ImmW = WIDTH - 8;
  localparam int unsigned OffW = WIDTH - 4;
  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;

  state_e           state_q, state_d;
  logic             run_q;
  logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]       flags_q, flags_d;  // {N, Z, C, V}
  logic [WIDTH-1:0] regs_q [4];
  logic             rf_we;

  logic [1:0] op, fn, rd, rn, rm;
  assign op = ir_q[WIDTH-1:WIDTH-2];
  assign fn = ir_q[WIDTH-3:WIDTH-4];
  assign rd = ir_q[WIDTH-5:WIDTH-6];
  assign rn = ir_q[WIDTH-7:WIDTH-8];
  assign rm = ir_q[1:0];

  logic [WIDTH-1:0] imm_zx, off_sx;
  assign imm_zx = {{8{1'b0}}, ir_q[ImmW-1:0]};
  assign off_sx = {{4{ir_q[OffW-1]}}, ir_q[OffW-1:0]};

  // run_q holds requests off until reset has been sampled high once, so every
  // bus output is a function of registered state only.
  logic access, accept;
  assign access = run_q && ((state_q == StFetch) || (state_q == StMem));
  assign accept = access && bus.mem_ready;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res = sum[WIDTH-1:0];
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (fn)
      2'b00: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      2'b01: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = ~diff[WIDTH];  // no borrow
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      2'b10:   alu_res = a_q & b_q;
      default: alu_res = a_q | b_q;
    endcase
  end

  logic taken;
  always_comb begin
    case (fn)
      2'b00:   taken = 1'b1;
      2'b01:   taken = flags_q[2];
      2'b10:   taken = ~flags_q[2];
      default: taken = flags_q[3] ^ flags_q[0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    flags_d    = flags_q;
    rf_we      = 1'b0;
    instr_done = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (accept) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + One;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d     = regs_q[rn];
        b_d     = (op == 2'b00) ? regs_q[rm] : imm_zx;
        state_d = StExec;
      end
      StExec: begin
        case (op)
          2'b00, 2'b01: begin
            res_d   = alu_res;
            flags_d = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
            state_d = StWb;
          end
          2'b10: begin
            res_d   = sum[WIDTH-1:0];  // effective address
            state_d = StMem;
          end
          default: begin
            if (taken) pc_d = pc_q + off_sx;
            instr_done = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMem: begin
        if (accept) begin
          if (fn[0]) begin
            res_d   = bus.mem_rdata;
            state_d = StWb;
          end else begin
            instr_done = 1'b1;
            state_d    = StFetch;
          end
        end
      end
      StWb: begin
        rf_we      = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFetch;
      run_q   <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      if (rf_we) regs_q[rd] <= res_q;
    end
  end

  assign bus.mem_req   = access;
  assign bus.mem_we    = run_q && (state_q == StMem) && !fn[0];
  assign bus.mem_addr  = !run_q ? '0 : ((state_q == StMem) ? res_q : pc_q);
  assign bus.mem_wdata = (run_q && (state_q == StMem)) ? regs_q[rd] : '0;
  assign pc            = pc_q;

endmodule
